// File: rtl/al_logic_dram_defs_pkg.sv
// Shared definitions for the multi-read-port distributed RAM: clear
// sequencer state encodings, read-during-write mode selectors and the
// write-lane count derivation.
package al_logic_dram_defs;

  // Clear sequencer states
  typedef enum logic [1:0] {
    ST_IDLE_RST = 2'd0,
    ST_CLEAR    = 2'd1,
    ST_READY    = 2'd2
  } seq_state_t;

  // Read-during-write behaviour selectors
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Number of write-enable lanes in a word
  function automatic int num_be(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/al_logic_dram_clr_seq.sv
// Reset / clear sequencer. After reset is released it optionally sweeps
// every word of the array to the init pattern, one word per cycle, and
// reports busy until the array is usable.
module al_logic_dram_clr_seq
  import al_logic_dram_defs::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_DEPTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

  seq_state_t            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  busy_reg;

  // State, sweep counter and busy flag; busy tracks the state being entered
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= ST_IDLE_RST;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next != ST_READY);
    end
  end

  // Next-state logic and clear-write strobe
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_we     = 1'b0;
    case (state_reg)
      ST_IDLE_RST: begin
        cnt_next   = '0;
        state_next = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      end
      ST_CLEAR: begin
        // An edge with reset asserted aborts the sweep without writing
        clr_we = rstn;
        if (cnt_reg == LAST_ADDR) begin
          cnt_next   = '0;
          state_next = ST_READY;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next = ST_IDLE_RST;
      end
    endcase
  end

  assign busy     = busy_reg;
  assign clr_addr = cnt_reg;

endmodule

// File: rtl/al_logic_dram_mp.sv
// Multi-read-port distributed RAM with per-lane write enables, optional
// registered read, selectable read-during-write data and a post-reset
// clear sweep. Read data is on dout (the name "do" is a reserved word).
module al_logic_dram_mp
  import al_logic_dram_defs::*;
#(
  parameter int                    DATA_WIDTH     = 9,
  parameter int                    ADDR_WIDTH     = 5,
  parameter int                    DATA_DEPTH     = 2**ADDR_WIDTH,
  parameter int                    BYTE_WIDTH     = 9,
  parameter int                    NUM_RPORTS     = 2,
  parameter int                    READ_REG       = 0,
  parameter string                 RDW_MODE       = "OLD",
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic [DATA_WIDTH-1:0]                      di,
  input  logic [ADDR_WIDTH-1:0]                      waddr,
  input  logic [num_be(DATA_WIDTH, BYTE_WIDTH)-1:0]  we,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0]           raddr,
  input  logic [NUM_RPORTS-1:0]                      re,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0]           dout,
  output logic                                       busy
);

  localparam int NUM_BE  = num_be(DATA_WIDTH, BYTE_WIDTH);
  localparam int RDW_SEL = (RDW_MODE == "NEW") ? RDW_NEW : RDW_OLD;

  // Parameter sanity checks
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_chk_lanes
    $error("al_logic_dram_mp: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if ((RDW_MODE != "OLD") && (RDW_MODE != "NEW")) begin : g_chk_rdw
    $error("al_logic_dram_mp: RDW_MODE must be \"OLD\" or \"NEW\"");
  end
  if (DATA_DEPTH > 2**ADDR_WIDTH) begin : g_chk_depth
    $error("al_logic_dram_mp: DATA_DEPTH exceeds the address range");
  end
  if ((NUM_RPORTS < 1) || (NUM_RPORTS > 4)) begin : g_chk_ports
    $error("al_logic_dram_mp: NUM_RPORTS must be 1..4");
  end

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  waddr_ok;
  logic [NUM_BE-1:0]     lane_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_BE-1:0]     wr_lanes;

  al_logic_dram_clr_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DATA_DEPTH     (DATA_DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr_seq (
    .clk      (clk),
    .rstn     (rstn),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // User lanes that actually land in the array: not busy, not in reset,
  // and the address falls inside the populated depth
  assign waddr_ok = ({1'b0, waddr} < (ADDR_WIDTH + 1)'(DATA_DEPTH));
  assign lane_we  = (rstn && !busy && waddr_ok) ? we : '0;

  // The sweep owns the write port while it runs
  assign wr_addr  = clr_we ? clr_addr : waddr;
  assign wr_data  = clr_we ? INIT_VALUE : di;
  assign wr_lanes = clr_we ? {NUM_BE{1'b1}} : lane_we;

  // Single write port, lane-masked
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_BE; k++) begin
      if (wr_lanes[k]) begin
        mem[wr_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RPORTS; gi++) begin : g_rport
    logic [ADDR_WIDTH-1:0] ra;
    logic                  ra_ok;
    logic [DATA_WIDTH-1:0] word_old;
    logic [DATA_WIDTH-1:0] word_rd;

    assign ra       = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign ra_ok    = ({1'b0, ra} < (ADDR_WIDTH + 1)'(DATA_DEPTH));
    assign word_old = ra_ok ? mem[ra] : '0;

    if (RDW_SEL == RDW_NEW) begin : g_new
      // Forward the lanes being written this cycle to a same-address read
      always_comb begin
        word_rd = word_old;
        if (waddr == ra) begin
          for (int k = 0; k < NUM_BE; k++) begin
            if (lane_we[k]) begin
              word_rd[k*BYTE_WIDTH +: BYTE_WIDTH] = di[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
          end
        end
      end
    end else begin : g_old
      assign word_rd = word_old;
    end

    if (READ_REG != 0) begin : g_reg
      logic [DATA_WIDTH-1:0] q_reg;

      // Registered read: cleared in reset and while busy, loads on re
      always_ff @(posedge clk) begin
        if (!rstn || busy) begin
          q_reg <= '0;
        end else if (re[gi]) begin
          q_reg <= word_rd;
        end
      end

      assign dout[gi*DATA_WIDTH +: DATA_WIDTH] = q_reg;
    end else begin : g_async
      // Read enable has no meaning for the combinational read path
      logic unused_re;
      assign unused_re = re[gi];
      assign dout[gi*DATA_WIDTH +: DATA_WIDTH] = busy ? '0 : word_rd;
    end
  end

endmodule
